sum_display_scanner: RTL and testbench

- Downstream stage of the 4-bit operand adder. Consumes its 8-bit sum and shows it in decimal on the board's 4-digit common-anode seven-segment display.
- Captures the sum on a load strobe. Converts binary to BCD sequentially (double-dabble, one bit per cycle). Time-multiplexes the digits at a parameterised refresh rate.

---
 rtl/sum_disp_pkg.sv | 30 +++
 rtl/seg7_decoder.sv | 28 ++
 rtl/sum_display_scanner.sv | 161 ++++++++++++++++
 tb/tb_sum_display_scanner.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sum_disp_pkg.sv
// Shared types and constants for the sum display scanner: FSM states,
// active-low seven-segment codes {g,f,e,d,c,b,a} and the double-dabble step.
package sum_disp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        UPDATE
    } state_t;

    localparam int NUM_DIGITS = 4;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Double-dabble correction: a nibble >= 5 would overflow past 9 once doubled.
    function automatic logic [3:0] add3_if_ge5(input logic [3:0] nib);
        return (nib >= 4'd5) ? nib + 4'd3 : nib;
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD-to-seven-segment decoder (active-low); codes 10..15 and
// the blank flag both produce an unlit digit.
module seg7_decoder
    import sum_disp_pkg::*;
(
    input  logic [3:0] bcd_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    always_comb begin
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
        endcase
        if (blank_i) seg_o = SEG_BLANK;
    end

endmodule

// File: rtl/sum_display_scanner.sv
// Captures the adder sum, converts it to BCD one bit per cycle and scans it
// onto a 4-digit common-anode display. Define LEADING_ZERO_BLANK_EN to blank leading zeros.
module sum_display_scanner
    import sum_disp_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int CNT_W       = 17
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            sum_i,
    input  logic                  load_i,
    output logic                  busy_o,
    output logic                  bcd_valid_o,
    output logic [6:0]            seg_o,
    output logic [NUM_DIGITS-1:0] an_o
);

    state_t                r_state;
    logic [7:0]            r_bin;
    logic [11:0]           r_bcd;
    logic [2:0]            r_bit_cnt;
    logic [7:0]            r_pend;
    logic                  r_pend_vld;
    logic                  r_busy;
    logic                  r_bcd_valid;
    logic [3:0]            r_hund;
    logic [3:0]            r_tens;
    logic [3:0]            r_ones;
    logic [CNT_W-1:0]      r_refresh_cnt;
    logic [1:0]            r_scan_idx;
    logic [6:0]            r_seg;
    logic [NUM_DIGITS-1:0] r_an;

    logic [11:0]           w_adj;
    logic [19:0]           w_shifted;
    logic [3:0]            w_digit;
    logic                  w_blank;
    logic [6:0]            w_seg;

    assign w_adj     = {add3_if_ge5(r_bcd[11:8]), add3_if_ge5(r_bcd[7:4]), add3_if_ge5(r_bcd[3:0])};
    assign w_shifted = {w_adj, r_bin} << 1;

    // NOTE: all state below uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_bin       <= '0;
            r_bcd       <= '0;
            r_bit_cnt   <= '0;
            r_pend      <= '0;
            r_pend_vld  <= 1'b0;
            r_busy      <= 1'b0;
            r_bcd_valid <= 1'b0;
            r_hund      <= '0;
            r_tens      <= '0;
            r_ones      <= '0;
        end else begin
            r_bcd_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (load_i) begin
                        r_bin     <= sum_i;
                        r_bcd     <= '0;
                        r_bit_cnt <= 3'd7;
                        r_busy    <= 1'b1;
                        r_state   <= CONVERT;
                    end
                end
                CONVERT: begin
                    {r_bcd, r_bin} <= w_shifted;
                    if (load_i) begin
                        r_pend     <= sum_i;
                        r_pend_vld <= 1'b1;
                    end
                    if (r_bit_cnt == 3'd0) begin
                        r_bcd_valid <= 1'b1;
                        r_state     <= UPDATE;
                    end else begin
                        r_bit_cnt <= r_bit_cnt - 3'd1;
                    end
                end
                UPDATE: begin
                    r_hund <= r_bcd[11:8];
                    r_tens <= r_bcd[7:4];
                    r_ones <= r_bcd[3:0];
                    // A queued value wins; a fresh load this cycle becomes the new queued one.
                    if (r_pend_vld || load_i) begin
                        r_bin      <= r_pend_vld ? r_pend : sum_i;
                        r_bcd      <= '0;
                        r_bit_cnt  <= 3'd7;
                        r_pend_vld <= r_pend_vld && load_i;
                        if (load_i) r_pend <= sum_i;
                        r_state    <= CONVERT;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    always_comb begin
        w_digit = r_ones;
        w_blank = 1'b0;
        case (r_scan_idx)
            2'd0: w_digit = r_ones;
            2'd1: begin
                w_digit = r_tens;
`ifdef LEADING_ZERO_BLANK_EN
                w_blank = (r_hund == 4'd0) && (r_tens == 4'd0);
`endif
            end
            2'd2: begin
                w_digit = r_hund;
`ifdef LEADING_ZERO_BLANK_EN
                w_blank = (r_hund == 4'd0);
`endif
            end
            default: w_blank = 1'b1;
        endcase
    end

    seg7_decoder u_seg7 (
        .bcd_i   (w_digit),
        .blank_i (w_blank),
        .seg_o   (w_seg)
    );

    // Segments and anodes load together at the start of each slot, so a new
    // value never shows up partway through a digit's dwell.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_refresh_cnt <= '0;
            r_scan_idx    <= '0;
            r_seg         <= SEG_BLANK;
            r_an          <= '1;
        end else begin
            if (r_refresh_cnt == CNT_W'(REFRESH_DIV - 1)) begin
                r_refresh_cnt <= '0;
                r_scan_idx    <= r_scan_idx + 2'd1;
            end else begin
                r_refresh_cnt <= r_refresh_cnt + 1'b1;
            end
            if (r_refresh_cnt == '0) begin
                r_an  <= ~(NUM_DIGITS'(1) << r_scan_idx);
                r_seg <= w_seg;
            end
        end
    end

    assign busy_o      = r_busy;
    assign bcd_valid_o = r_bcd_valid;
    assign seg_o       = r_seg;
    assign an_o        = r_an;

endmodule

// File: tb/tb_sum_display_scanner.sv
// Randomised scoreboard bench for sum_display_scanner; expected pulses and
// digits come from a transaction-level model using decimal arithmetic.
module tb_sum_display_scanner;

    localparam int REFRESH_DIV = 4;
    localparam int CNT_W       = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] sum_i = '0;
    logic       load_i = 1'b0;
    logic       busy_o;
    logic       bcd_valid_o;
    logic [6:0] seg_o;
    logic [3:0] an_o;

    sum_display_scanner #(.REFRESH_DIV(REFRESH_DIV), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sum_i       (sum_i),
        .load_i      (load_i),
        .busy_o      (busy_o),
        .bcd_valid_o (bcd_valid_o),
        .seg_o       (seg_o),
        .an_o        (an_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected segment pattern, built from active-high {g..a} shapes.
    function automatic logic [6:0] seg_of(input int d);
        logic [6:0] hi;
        case (d)
            0: hi = 7'b0111111;
            1: hi = 7'b0000110;
            2: hi = 7'b1011011;
            3: hi = 7'b1001111;
            4: hi = 7'b1100110;
            5: hi = 7'b1101101;
            6: hi = 7'b1111101;
            7: hi = 7'b0000111;
            8: hi = 7'b1111111;
            9: hi = 7'b1101111;
            default: hi = 7'b0000000;
        endcase
        return ~hi;
    endfunction

    function automatic logic [6:0] exp_seg(input int v, input int idx);
        int  h = v / 100;
        int  t = (v / 10) % 10;
        int  o = v % 10;
        bit  blank = 1'b0;
        int  d = o;
        if (idx == 3) return 7'h7F;
        if (idx == 1) d = t;
        if (idx == 2) d = h;
`ifdef LEADING_ZERO_BLANK_EN
        if (idx == 2 && h == 0) blank = 1'b1;
        if (idx == 1 && h == 0 && t == 0) blank = 1'b1;
`endif
        return blank ? 7'h7F : seg_of(d);
    endfunction

    typedef struct {
        int val;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   m_start = -1;
    int   m_end = -1;
    bit   m_pend_vld = 1'b0;
    int   m_pend = 0;

    task automatic push(input int v, input int c);
        exp_t e;
        e.val = v;
        e.cyc = c;
        sb.push_back(e);
    endtask

    // One clock of stimulus; the model predicts when each value is shown.
    task automatic tick(input bit ld, input int v);
        @(negedge clk);
        load_i = ld;
        sum_i  = 8'(v);
        if (cyc == m_end && (ld || m_pend_vld)) begin
            if (m_pend_vld) begin
                push(m_pend, cyc + 9);
                m_pend_vld = ld;
                m_pend     = v;
            end else begin
                push(v, cyc + 9);
            end
            m_start = cyc;
            m_end   = cyc + 9;
        end else if (ld && cyc > m_start && cyc < m_end) begin
            m_pend     = v;
            m_pend_vld = 1'b1;
        end else if (ld) begin
            push(v, cyc + 9);
            m_start = cyc;
            m_end   = cyc + 9;
        end
    endtask

    task automatic model_reset();
        sb.delete();
        m_start    = -1;
        m_end      = -1;
        m_pend_vld = 1'b0;
    endtask

    task automatic check_reset_outputs();
        check("rst_seg", seg_o, 7'h7F);
        check("rst_an", an_o, 4'hF);
        check("rst_busy", busy_o, 1'b0);
        check("rst_valid", bcd_valid_o, 1'b0);
    endtask

    // Monitor: pops the scoreboard on bcd_valid_o and checks every new scan slot.
    int         disp_cur = 0;
    int         disp_prev = 0;
    int         upd_cyc = -100;
    logic [3:0] prev_an = 4'hF;
    logic [6:0] last_seg = 7'h7F;
    int         last_idx = 0;
    int         slot_cyc = 0;
    bit         first_slot = 1'b1;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                disp_cur   = 0;
                disp_prev  = 0;
                upd_cyc    = -100;
                prev_an    = 4'hF;
                last_seg   = 7'h7F;
                first_slot = 1'b1;
            end else begin
                check("busy", busy_o, (cyc > m_start && cyc <= m_end));
                if (sb.size() > 0 && sb[0].cyc == cyc) begin
                    exp_t e;
                    check("bcd_valid_pulse", bcd_valid_o, 1'b1);
                    e         = sb.pop_front();
                    disp_prev = disp_cur;
                    disp_cur  = e.val;
                    upd_cyc   = cyc;
                end else begin
                    check("bcd_valid_idle", bcd_valid_o, 1'b0);
                end
                if (an_o != prev_an) begin
                    int         idx;
                    int         shown;
                    logic [3:0] exp_an;
                    idx    = first_slot ? 0 : (last_idx + 1) % 4;
                    exp_an = ~(4'b0001 << idx);
                    check("an_o", an_o, exp_an);
                    if (!first_slot) check("dwell", cyc - slot_cyc, REFRESH_DIV);
                    shown = (cyc >= upd_cyc + 2) ? disp_cur : disp_prev;
                    check("seg_o", seg_o, exp_seg(shown, idx));
                    last_idx   = idx;
                    slot_cyc   = cyc;
                    first_slot = 1'b0;
                    prev_an    = an_o;
                    last_seg   = seg_o;
                end else begin
                    check("seg_stable", seg_o, last_seg);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;

        repeat (20) tick(0, 0);
        tick(1, 30);
        repeat (26) tick(0, 0);
        tick(1, 255);
        repeat (26) tick(0, 0);
        tick(1, 0);
        repeat (26) tick(0, 0);

        // Back-to-back loads: 9 is overwritten by 12 before it is consumed.
        tick(1, 17);
        tick(0, 0);
        tick(0, 0);
        tick(1, 9);
        tick(1, 12);
        repeat (30) tick(0, 0);

        // Reset partway through a conversion with a queued value.
        tick(1, 100);
        tick(0, 0);
        tick(1, 200);
        tick(0, 0);
        tick(0, 0);
        @(negedge clk);
        load_i = 1'b0;
        rst_n  = 1'b0;
        #1;
        model_reset();
        check_reset_outputs();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) tick(0, 0);

        repeat (60) begin
            tick(1, int'($urandom_range(0, 255)));
            repeat ($urandom_range(0, 12)) tick(0, 0);
        end
        repeat (40) tick(0, 0);
        check("scoreboard_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
